soft_oserdes_gearbox: RTL and testbench

Parametrised fabric serializer and successor to the single-lane hard OSERDES test. It accepts CHANNELS parallel words of DATA_WIDTH bits each through a one-word skid buffer with a valid/ready handshake, and shifts the words out LSB-first, one bit per clk. It generates its own word-rate divided clock, inserts an idle pattern on underflow, drives per-lane tristate control, and counts underflow events. It sits between a word-rate data source and the IO buffers.

---
 rtl/soft_oserdes_gearbox.sv | 112 +++++++++++
 tb/tb_soft_oserdes_gearbox.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soft_oserdes_gearbox.sv
// Multi-lane fabric serializer: skid-buffered word input, LSB-first shift-out, idle fill on underflow.
// Optional macro SOFT_OSERDES_TRAIN_EN adds a train input that loads a 0101... pattern at boundaries.
module soft_oserdes_gearbox #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    CHANNELS      = 1,
    parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN  = '0,
    parameter bit                    IDLE_TRISTATE = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
`ifdef SOFT_OSERDES_TRAIN_EN
    input  logic                           train,
`endif
    output logic [CHANNELS-1:0]            oq,
    output logic [CHANNELS-1:0]            t_out,
    output logic                           clk_div,
    output logic                           word_strobe,
    output logic [15:0]                    underflow_cnt
);

    localparam int              CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]   HALF = CW'(DATA_WIDTH / 2);
    localparam logic [2*DATA_WIDTH-1:0] ALT2 = {DATA_WIDTH{2'b01}};
    localparam logic [DATA_WIDTH-1:0]   ALT  = ALT2[DATA_WIDTH-1:0];

    typedef logic [CHANNELS-1:0][DATA_WIDTH-1:0] lanes_t;

    logic [CW-1:0]                   bit_cnt;
    logic [CW-1:0]                   bit_cnt_next;
    logic                            boundary;
    logic                            buf_full;
    logic [CHANNELS*DATA_WIDTH-1:0]  skid_data;
    lanes_t                          skid_lanes;
    lanes_t                          sr;
    lanes_t                          sr_next;
    logic [CHANNELS-1:0]             t_next;
    logic [CHANNELS-1:0]             oq_next;
    logic                            load_idle;
    logic                            accept;
    logic                            train_load;

`ifdef SOFT_OSERDES_TRAIN_EN
    assign train_load = train;
`else
    assign train_load = 1'b0;
`endif

    assign in_ready   = !buf_full && !rst;
    assign accept     = in_valid && in_ready;
    assign skid_lanes = skid_data;

    // Boundary cycle reloads every lane; training takes priority and leaves the buffer untouched.
    always_comb begin
        boundary     = (bit_cnt == LAST);
        bit_cnt_next = boundary ? '0 : bit_cnt + 1'b1;
        sr_next      = sr;
        t_next       = t_out;
        load_idle    = 1'b0;
        oq_next      = '0;
        if (boundary) begin
            if (train_load) begin
                for (int k = 0; k < CHANNELS; k++) sr_next[k] = ALT;
                t_next = '0;
            end else if (buf_full) begin
                sr_next = skid_lanes;
                t_next  = '0;
            end else begin
                for (int k = 0; k < CHANNELS; k++) sr_next[k] = IDLE_PATTERN;
                t_next    = {CHANNELS{IDLE_TRISTATE}};
                load_idle = 1'b1;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) sr_next[k] = sr[k] >> 1;
        end
        for (int k = 0; k < CHANNELS; k++) oq_next[k] = sr_next[k][0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt       <= '0;
            buf_full      <= 1'b0;
            skid_data     <= '0;
            sr            <= {CHANNELS{IDLE_PATTERN}};
            t_out         <= '1;
            oq            <= '0;
            clk_div       <= 1'b1;
            word_strobe   <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            bit_cnt     <= bit_cnt_next;
            sr          <= sr_next;
            t_out       <= t_next;
            oq          <= oq_next;
            clk_div     <= (bit_cnt_next < HALF);
            word_strobe <= (bit_cnt_next == LAST);
            // Accept needs an empty buffer and a load needs a full one, so they never collide.
            if (accept) begin
                skid_data <= in_data;
                buf_full  <= 1'b1;
            end else if (boundary && buf_full && !train_load) begin
                buf_full <= 1'b0;
            end
            if (load_idle && underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_soft_oserdes_gearbox.sv
// Directed bench: a 4-lane 8-bit instance plus a 2-lane 5-bit instance driving a non-tristate idle word.
module tb_soft_oserdes_gearbox;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  oq;
    logic [3:0]  t_out;
    logic        clk_div;
    logic        word_strobe;
    logic [15:0] underflow_cnt;
    logic        train;

    logic [9:0]  d2_in_data;
    logic        d2_ready;
    logic [1:0]  d2_oq;
    logic [1:0]  d2_t;
    logic        d2_div;
    logic        d2_strobe;
    logic [15:0] d2_cnt;

    localparam logic [4:0] IDLE2 = 5'b10110;

    soft_oserdes_gearbox #(
        .DATA_WIDTH(8), .CHANNELS(4), .IDLE_PATTERN(8'h00), .IDLE_TRISTATE(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef SOFT_OSERDES_TRAIN_EN
        .train(train),
`endif
        .oq(oq), .t_out(t_out), .clk_div(clk_div), .word_strobe(word_strobe),
        .underflow_cnt(underflow_cnt)
    );

    soft_oserdes_gearbox #(
        .DATA_WIDTH(5), .CHANNELS(2), .IDLE_PATTERN(IDLE2), .IDLE_TRISTATE(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst), .in_data(d2_in_data), .in_valid(1'b0), .in_ready(d2_ready),
`ifdef SOFT_OSERDES_TRAIN_EN
        .train(1'b0),
`endif
        .oq(d2_oq), .t_out(d2_t), .clk_div(d2_div), .word_strobe(d2_strobe),
        .underflow_cnt(d2_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       valid;
        logic       ready;
        logic [3:0] oq;
        logic [3:0] t;
        logic       strobe;
        logic       div;
    } vec_t;
    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Leaves the bench at a falling edge with rst just released: that cycle is cycle 1.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        train = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] words[3];
        logic [7:0] cur;
        int idx;

        rst = 1'b1; in_valid = 1'b0; train = 1'b0; in_data = '0; d2_in_data = '0;
        cur = '0;

        vecs[0]  = '{1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'hB, 4'h0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 4'h2, 4'h0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 4'h7, 4'h0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 4'h6, 4'h0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 4'h6, 4'h0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 4'h7, 4'h0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 4'h2, 4'h0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 4'hB, 4'h0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1};

        // Idle run on both instances, then counter saturation.
        do_reset();
        for (int n = 1; n <= 41; n++) begin
            #1;
            check($sformatf("idle_oq c%0d", n), oq, 4'h0);
            check($sformatf("idle_t c%0d", n), t_out, 4'hF);
            check($sformatf("idle_strobe c%0d", n), word_strobe, (n % 8 == 0));
            check($sformatf("idle_div c%0d", n), clk_div, ((n - 1) % 8 < 4));
            check($sformatf("idle_cnt c%0d", n), underflow_cnt, (n - 1) / 8);
            check($sformatf("d2_div c%0d", n), d2_div, ((n - 1) % 5 < 2));
            check($sformatf("d2_strobe c%0d", n), d2_strobe, (n % 5 == 0));
            check($sformatf("d2_cnt c%0d", n), d2_cnt, (n - 1) / 5);
            if (n == 1) check("d2_oq_reset", d2_oq, 2'b00);
            if (n <= 5) check($sformatf("d2_t c%0d", n), d2_t, 2'b11);
            else begin
                check($sformatf("d2_t c%0d", n), d2_t, 2'b00);
                check($sformatf("d2_oq c%0d", n), d2_oq, {2{IDLE2[(n - 6) % 5]}});
            end
            @(negedge clk);
        end
        force dut.underflow_cnt = 16'hFFFE;
        #1;
        release dut.underflow_cnt;
        for (int n = 42; n <= 65; n++) begin
            #1;
            if (n == 49 || n == 57 || n == 65)
                check($sformatf("sat_cnt c%0d", n), underflow_cnt, 16'hFFFF);
            @(negedge clk);
        end

        // Single word, table driven.
        do_reset();
        in_data = {8'h81, 8'h3C, 8'hFF, 8'hA5};
        for (int i = 0; i < 17; i++) begin
            in_valid = vecs[i].valid;
            #1;
            check($sformatf("vec_ready c%0d", i + 1), in_ready, vecs[i].ready);
            check($sformatf("vec_oq c%0d", i + 1), oq, vecs[i].oq);
            check($sformatf("vec_t c%0d", i + 1), t_out, vecs[i].t);
            check($sformatf("vec_strobe c%0d", i + 1), word_strobe, vecs[i].strobe);
            check($sformatf("vec_div c%0d", i + 1), clk_div, vecs[i].div);
            @(negedge clk);
        end
        check("vec_cnt", underflow_cnt, 16'd1);

        // Back-to-back words with in_valid held high.
        do_reset();
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
        idx = 0;
        for (int n = 1; n <= 33; n++) begin
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? {4{words[idx]}} : '0;
            #1;
            check($sformatf("b2b_ready c%0d", n), in_ready,
                  (n == 1 || n == 9 || n == 17 || n >= 25));
            if (n == 9 || n == 17 || n == 25) begin
                check($sformatf("b2b_queue c%0d", n), exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) cur = exp_q.pop_front();
            end
            if (n >= 9 && n <= 32) begin
                check($sformatf("b2b_oq c%0d", n), oq, {4{cur[(n - 9) % 8]}});
                check($sformatf("b2b_t c%0d", n), t_out, 4'h0);
            end else begin
                check($sformatf("b2b_oq c%0d", n), oq, 4'h0);
                check($sformatf("b2b_t c%0d", n), t_out, 4'hF);
            end
            check($sformatf("b2b_cnt c%0d", n), underflow_cnt, (n == 33) ? 1 : 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(words[idx]);
                idx++;
            end
            @(negedge clk);
        end

        // Reset mid-word with a full buffer.
        do_reset();
        in_data = {4{8'hFF}};
        for (int n = 1; n <= 13; n++) begin
            in_valid = (n == 1 || n == 9);
            #1;
            if (n < 13) @(negedge clk);
        end
        check("mid_ready", in_ready, 1'b0);
        check("mid_oq", oq, 4'hF);
        check("mid_t", t_out, 4'h0);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_ready_now", in_ready, 1'b0);
        @(negedge clk);
        #1;
        check("rst_t", t_out, 4'hF);
        check("rst_oq", oq, 4'h0);
        check("rst_ready", in_ready, 1'b0);
        check("rst_strobe", word_strobe, 1'b0);
        check("rst_div", clk_div, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            #1;
            check($sformatf("post_oq c%0d", n), oq, 4'h0);
            check($sformatf("post_t c%0d", n), t_out, 4'hF);
            check($sformatf("post_ready c%0d", n), in_ready, 1'b1);
            @(negedge clk);
        end
        check("post_cnt", underflow_cnt, 16'd2);

`ifdef SOFT_OSERDES_TRAIN_EN
        // Training over two boundaries while a word waits in the buffer.
        do_reset();
        in_data = {4{8'hA5}};
        cur = 8'hA5;
        for (int n = 1; n <= 33; n++) begin
            in_valid = (n == 1);
            train    = (n >= 2 && n <= 16);
            #1;
            check($sformatf("trn_ready c%0d", n), in_ready, (n == 1 || n >= 25));
            if (n <= 8) begin
                check($sformatf("trn_oq c%0d", n), oq, 4'h0);
                check($sformatf("trn_t c%0d", n), t_out, 4'hF);
            end else if (n <= 24) begin
                check($sformatf("trn_oq c%0d", n), oq, ((n - 9) % 2 == 0) ? 4'hF : 4'h0);
                check($sformatf("trn_t c%0d", n), t_out, 4'h0);
            end else if (n <= 32) begin
                check($sformatf("trn_oq c%0d", n), oq, {4{cur[n - 25]}});
                check($sformatf("trn_t c%0d", n), t_out, 4'h0);
            end
            check($sformatf("trn_cnt c%0d", n), underflow_cnt, (n == 33) ? 1 : 0);
            @(negedge clk);
        end
        train = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
